divider_64b_32b_seq: RTL

// - Sequential unsigned 64/32 restoring divider; the inverse of the 32b multiplier (a*b -> quotient/remainder).
// - Accepts a 64-bit dividend and a 32-bit divisor; returns a 32-bit quotient and a 32-bit remainder.
// - Resolves 1 quotient bit per cycle (2 with macro); valid/ready handshake on both sides; sits beside the multiplier in the arithmetic unit.

---
 rtl/divider_pkg.sv | 16 +
 rtl/divider_step.sv | 23 ++
 rtl/divider_64b_32b_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared widths, FSM states and constants for the sequential 64/32 divider.
// DIVIDER_64B_32B_SEQ_RADIX4_EN selects two restoring steps per cycle.
package divider_pkg;
  localparam int DVD_W = 64;
  localparam int DVS_W = 32;
  localparam int CNT_W = 5;
`ifdef DIVIDER_64B_32B_SEQ_RADIX4_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DVS_W / STEPS - 1);
  localparam logic [DVS_W-1:0] SAT      = '1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/divider_step.sv
// One combinational restoring iteration: shift {R,Q} left, try R-D, keep if non-negative.
module divider_step
  import divider_pkg::*;
(
  input  logic [DVS_W:0]   r_i,
  input  logic [DVS_W-1:0] q_i,
  input  logic [DVS_W-1:0] d_i,
  output logic [DVS_W:0]   r_o,
  output logic [DVS_W-1:0] q_o
);
  logic [DVS_W:0]   r_sh;
  logic [DVS_W+1:0] t;
  logic             ge;

  always_comb begin
    r_sh = {r_i[DVS_W-1:0], q_i[DVS_W-1]};
    t    = {1'b0, r_sh} - {2'b00, d_i};
    // a set bit shifted out of R means the partial remainder already exceeds D
    ge   = r_i[DVS_W] | ~t[DVS_W+1];
    r_o  = ge ? t[DVS_W:0] : r_sh;
    q_o  = {q_i[DVS_W-2:0], ge};
  end
endmodule

// File: rtl/divider_64b_32b_seq.sv
// Sequential unsigned 64/32 restoring divider with valid/ready on both sides.
// DIVIDER_64B_32B_SEQ_RADIX4_EN chains two divider_step instances per cycle.
module divider_64b_32b_seq
  import divider_pkg::*;
(
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iEn,
  input  logic             iClr,
  input  logic             iValid,
  output logic             oReady,
  input  logic [DVD_W-1:0] iData0,
  input  logic [DVS_W-1:0] iData1,
  output logic             oValid,
  input  logic             iReady,
  output logic [DVS_W-1:0] oQuot,
  output logic [DVS_W-1:0] oRem,
  output logic             oDivZero,
  output logic             oOvf
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DVS_W:0]   r_q, r_d;
  logic [DVS_W-1:0] q_q, q_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
  logic             vld_q, vld_d, dz_q, dz_d, ovf_q, ovf_d;

  logic [DVS_W:0]   r_c [STEPS+1];
  logic [DVS_W-1:0] q_c [STEPS+1];

  assign r_c[0] = r_q;
  assign q_c[0] = q_q;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    divider_step u_step (
      .r_i (r_c[i]),
      .q_i (q_c[i]),
      .d_i (d_q),
      .r_o (r_c[i+1]),
      .q_o (q_c[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    vld_d   = vld_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    if (iClr) begin
      state_d = IDLE;
      cnt_d   = '0;
      vld_d   = 1'b0;
      quot_d  = '0;
      rem_d   = '0;
      dz_d    = 1'b0;
      ovf_d   = 1'b0;
    end else if (iEn) begin
      case (state_q)
        IDLE: if (iValid) begin
          dz_d  = 1'b0;
          ovf_d = 1'b0;
          if (iData1 == '0) begin
            state_d = DONE;
            vld_d   = 1'b1;
            dz_d    = 1'b1;
            quot_d  = SAT;
            rem_d   = iData0[DVS_W-1:0];
          end else if (iData0[DVD_W-1:DVS_W] >= iData1) begin
            state_d = DONE;
            vld_d   = 1'b1;
            ovf_d   = 1'b1;
            quot_d  = SAT;
            rem_d   = iData0[DVS_W-1:0];
          end else begin
            state_d = BUSY;
            r_d     = {1'b0, iData0[DVD_W-1:DVS_W]};
            q_d     = iData0[DVS_W-1:0];
            d_d     = iData1;
            cnt_d   = CNT_INIT;
          end
        end
        BUSY: begin
          r_d   = r_c[STEPS];
          q_d   = q_c[STEPS];
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE;
            cnt_d   = '0;
            vld_d   = 1'b1;
            quot_d  = q_c[STEPS];
            rem_d   = r_c[STEPS][DVS_W-1:0];
          end
        end
        DONE: if (iReady) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oReady   = (state_q == IDLE);
  assign oValid   = vld_q;
  assign oQuot    = quot_q;
  assign oRem     = rem_q;
  assign oDivZero = dz_q;
  assign oOvf     = ovf_q;
endmodule
